// File: rtl/parity_mult_responder_if.sv
// Request/acknowledge bundle between a multiplier requester and the parity_mult_responder.
// The requester drives the operands and the DUT returns the ack, the result and its status.
interface parity_mult_responder_if #(
  parameter int DATA_W = 16
);
  logic                  req;
  logic [DATA_W-1:0]     arg_a;
  logic                  arg_a_parity;
  logic [DATA_W-1:0]     arg_b;
  logic                  arg_b_parity;
  logic                  ack;
  logic [2*DATA_W-1:0]   result;
  logic                  result_parity;
  logic                  result_rdy;
  logic                  arg_parity_error;

  modport master (
    output req, arg_a, arg_a_parity, arg_b, arg_b_parity,
    input  ack, result, result_parity, result_rdy, arg_parity_error
  );

  modport slave (
    input  req, arg_a, arg_a_parity, arg_b, arg_b_parity,
    output ack, result, result_parity, result_rdy, arg_parity_error
  );
endinterface

// File: rtl/parity_mult_responder.sv
// Parity-checked signed multiplier responder: checks operand parity, then forms the product
// with a DATA_W-cycle sign-magnitude shift-add loop and returns it with its own parity.
module parity_mult_responder #(
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  parity_mult_responder_if.slave  bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE, ERR} state_t;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  rdy_q, rdy_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  rpar_q, rpar_d;
  logic                  perr_q, perr_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sign_q, sign_d;

  logic                  par_err;
  logic [DATA_W-1:0]     mag_a, mag_b;
  logic [2*DATA_W-1:0]   acc_sum, prod;

  // -2^(DATA_W-1) negates to itself, which read unsigned is exactly its magnitude.
  assign mag_a   = bus.arg_a[DATA_W-1] ? (-bus.arg_a) : bus.arg_a;
  assign mag_b   = bus.arg_b[DATA_W-1] ? (-bus.arg_b) : bus.arg_b;
  assign par_err = (bus.arg_a_parity != ^bus.arg_a) | (bus.arg_b_parity != ^bus.arg_b);
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod    = sign_q ? (-acc_sum) : acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
      result_q <= '0;
      rpar_q   <= 1'b0;
      perr_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rdy_q    <= rdy_d;
      result_q <= result_d;
      rpar_q   <= rpar_d;
      perr_q   <= perr_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
    end
  end

  // Results are loaded on the edge entering ERR/DONE so they are visible alongside result_rdy.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    rdy_d    = 1'b0;
    result_d = result_q;
    rpar_d   = rpar_q;
    perr_d   = perr_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          ack_d = 1'b1;
          if (par_err) begin
            state_d  = ERR;
            result_d = '0;
            rpar_d   = 1'b0;
            perr_d   = 1'b1;
            rdy_d    = 1'b1;
          end else begin
            state_d  = CALC;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, mag_a};
            mplier_d = mag_b;
            sign_d   = bus.arg_a[DATA_W-1] ^ bus.arg_b[DATA_W-1];
          end
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          result_d = prod;
          rpar_d   = ^prod;
          perr_d   = 1'b0;
          rdy_d    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ack              = ack_q;
  assign bus.result_rdy       = rdy_q;
  assign bus.result           = result_q;
  assign bus.result_parity    = rpar_q;
  assign bus.arg_parity_error = perr_q;
endmodule

// File: tb/tb_parity_mult_responder.sv
// Self-checking bench for parity_mult_responder: directed cases plus random operands
// compared against a plain signed-arithmetic product model.
module tb_parity_mult_responder;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  parity_mult_responder_if #(.DATA_W(W)) bus ();
  parity_mult_responder #(.DATA_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[2*W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for the sampling edge, check ack, then scramble the inputs.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic pa, input logic pb);
    @(negedge clk);
    bus.arg_a = a; bus.arg_b = b; bus.arg_a_parity = pa; bus.arg_b_parity = pb;
    bus.req = 1'b1;
    @(posedge clk); #1;
    chk("ack", bus.ack, 1);
    bus.req = 1'b0;
    bus.arg_a = W'($urandom); bus.arg_b = W'($urandom);
    bus.arg_a_parity = 1'($urandom); bus.arg_b_parity = 1'($urandom);
  endtask

  task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic pa, input logic pb);
    logic err;
    logic [2*W-1:0] exp_res;
    int lat;
    err = (pa !== ^a) || (pb !== ^b);
    exp_res = err ? '0 : model(a, b);
    lat = 1;
    while (bus.result_rdy !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, err ? 1 : W + 1);
    chk("result", bus.result, exp_res);
    chk("result_parity", bus.result_parity, ^exp_res);
    chk("arg_parity_error", bus.arg_parity_error, err);
    $display("op a=%h b=%h pa=%b pb=%b -> result=%h rpar=%b perr=%b lat=%0d",
             a, b, pa, pb, bus.result, bus.result_parity, bus.arg_parity_error, lat);
    @(posedge clk); #1;
    chk("rdy_pulse", bus.result_rdy, 0);
    chk("ack_pulse", bus.ack, 0);
    chk("hold_result", bus.result, exp_res);
    chk("hold_perr", bus.arg_parity_error, err);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic pa, input logic pb);
    start(a, b, pa, pb);
    wait_result(a, b, pa, pb);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] edge_vals [5];
    int ack_at [4];
    int rdy_at [4];
    int n_ack, n_rdy, rdy_seen;

    edge_vals[0] = 16'h8000; edge_vals[1] = 16'h7FFF; edge_vals[2] = 16'h0000;
    edge_vals[3] = 16'h0001; edge_vals[4] = 16'hFFFF;
    bus.req = 1'b0; bus.arg_a = '0; bus.arg_b = '0;
    bus.arg_a_parity = 1'b0; bus.arg_b_parity = 1'b0;

    #1;
    chk("reset_result", bus.result, 0);
    chk("reset_rdy", bus.result_rdy, 0);
    chk("reset_ack", bus.ack, 0);
    chk("reset_perr", bus.arg_parity_error, 0);
    chk("reset_rpar", bus.result_parity, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(16'd3, 16'd5, 1'b0, 1'b0);
    op(16'hFFFE, 16'd3, 1'b1, 1'b0);
    op(16'h8000, 16'h8000, 1'b1, 1'b1);
    op(16'h8000, 16'h0000, 1'b1, 1'b0);
    op(16'd7, 16'd9, 1'b0, 1'b0);
    op(16'd6, 16'd7, 1'b0, 1'b1);
    op(16'hFFFF, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = (i % 4 == 1) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      rb = (i % 5 == 2) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      op(ra, rb, (^ra) ^ ($urandom_range(0, 7) == 0), (^rb) ^ ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset in the middle of a calculation.
    start(16'd100, 16'd100, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_result", bus.result, 0);
    chk("midreset_rdy", bus.result_rdy, 0);
    chk("midreset_perr", bus.arg_parity_error, 0);
    chk("midreset_rpar", bus.result_parity, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.result_rdy === 1'b1) rdy_seen++;
    end
    chk("no_rdy_after_reset", rdy_seen, 0);
    op(16'd4, 16'd4, 1'b1, 1'b1);

    // req held high: second sample on the first IDLE cycle after DONE.
    @(negedge clk);
    bus.arg_a = 16'd2; bus.arg_b = 16'd3; bus.arg_a_parity = 1'b1; bus.arg_b_parity = 1'b0;
    bus.req = 1'b1;
    @(posedge clk);
    n_ack = 0; n_rdy = 0;
    for (int i = 1; i <= 36; i++) begin
      #1;
      if (bus.ack === 1'b1 && n_ack < 4) begin ack_at[n_ack] = i; n_ack++; end
      if (bus.result_rdy === 1'b1 && n_rdy < 4) begin
        rdy_at[n_rdy] = i; n_rdy++;
        chk("b2b_result", bus.result, 6);
      end
      if (i == 19) bus.req = 1'b0;
      @(posedge clk);
    end
    #1;
    $display("b2b acks=%0d rdys=%0d", n_ack, n_rdy);
    chk("b2b_n_ack", n_ack, 2);
    chk("b2b_n_rdy", n_rdy, 2);
    if (n_ack == 2) begin
      chk("b2b_ack0", ack_at[0], 1);
      chk("b2b_ack1", ack_at[1], 19);
    end
    if (n_rdy == 2) begin
      chk("b2b_rdy0", rdy_at[0], 17);
      chk("b2b_rdy1", rdy_at[1], 35);
    end

    op(16'd7, 16'd1, 1'b0, 1'b1);
    op(16'd8, 16'd8, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/parity_mult_responder.md
Name: parity_mult_responder

Overview:
DUT-side responder for the multiplier request/acknowledge protocol that the stimulus generator, scoreboard and coverage classes drive and check. It accepts two signed operands, each carrying an even-parity bit. It checks parity and either flags an argument parity error or computes the signed product with an iterative shift-add datapath. It returns the result with its own parity bit and a one-cycle ready strobe.

Parameters:
DATA_W, 16, operand width in bits; the result is 2*DATA_W bits wide.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req  input  1  operation request; level-sampled only in IDLE.
arg_a  input  DATA_W  operand A, two's complement.
arg_a_parity  input  1  parity bit for A; correct value is ^arg_a.
arg_b  input  DATA_W  operand B, two's complement.
arg_b_parity  input  1  parity bit for B; correct value is ^arg_b.
ack  output  1  one-cycle pulse: operands captured.
result  output  2*DATA_W  signed product, or 0 on parity error.
result_parity  output  1  ^result.
result_rdy  output  1  one-cycle pulse: result, result_parity and arg_parity_error are valid.
arg_parity_error  output  1  either operand failed its parity check.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; ack, result_rdy, arg_parity_error, result_parity = 0; result = 0; counter and datapath registers cleared.
- States: IDLE, CALC, DONE, ERR.
- IDLE, req=1 at edge T: capture arg_a, arg_b and both parity bits.
  - ack=1 during cycle T+1 only.
  - Parity check on captured values: err = (arg_a_parity != ^arg_a) | (arg_b_parity != ^arg_b).
  - err=1 -> go to ERR. err=0 -> go to CALC with counter=0.
- ERR (single cycle, T+1): result=0, result_parity=0, arg_parity_error=1, result_rdy=1 in the same cycle as ack. Next state IDLE.
- CALC:
  - On capture, take magnitudes |a| and |b| and record sign = a[MSB]^b[MSB].
  - Each cycle examine one multiplier bit, LSB first, and conditionally add the shifted multiplicand into the 2*DATA_W accumulator.
  - After exactly DATA_W cycles (cycles T+1..T+DATA_W) go to DONE.
- DONE (cycle T+DATA_W+1):
  - result = sign ? -acc : acc, truncated to 2*DATA_W bits.
  - result_parity = ^result; arg_parity_error=0; result_rdy=1.
  - Next state IDLE.
- Latency: valid operation, req-sample edge to result_rdy high = DATA_W+1 cycles (17 at default). Parity error = 1 cycle.
- result, result_parity and arg_parity_error hold their values after result_rdy until the next result_rdy or reset.
- req is ignored in CALC, DONE and ERR; operand changes while busy have no effect.
- The requester drops req after seeing ack. If req is still high on the first IDLE cycle, a new operation starts on that edge; no idle gap is required.
- Magnitude of -2^(DATA_W-1) is 2^(DATA_W-1), held in DATA_W bits unsigned. The product -2^(DATA_W-1) * -2^(DATA_W-1) = 2^(2*DATA_W-2) fits without overflow.
- Zero operand: the full DATA_W-cycle latency still applies. Result 0 with sign=1 must yield 0, never negative zero.
- Reset mid-CALC: the operation is abandoned with no result_rdy, and outputs clear immediately.

Test Plan:
1. arg_a=3, arg_b=5, correct parities, req held until ack -> ack at T+1, result_rdy at T+17; result=15, result_parity=0, arg_parity_error=0.
2. arg_a=-2 (0xFFFE), arg_b=3 -> result=0xFFFFFFFA, result_parity=0, result_rdy at T+17.
3. arg_a=0x8000, arg_b=0x8000 -> result=0x40000000, result_parity=1. Repeat with arg_b=0 -> result=0, result_parity=0.
4. arg_a=7 with arg_a_parity=0 (correct is 1), arg_b valid -> ack and result_rdy both at T+1; arg_parity_error=1, result=0. The next valid op clears arg_parity_error.
5. Start 100*100, assert rst_n=0 at T+8 for 2 cycles -> outputs 0 immediately, no result_rdy. A following 4*4 returns 16 at its own T+17.
6. req held high continuously with operands 2,3 -> acks at T+1 and T+19; result_rdy at T+17 and T+35; each result=6; no req sampled during CALC.
